// File: rtl/checkers_pkg.sv
// Shared definitions for the checkers victory path.
//   game_state_t : IDLE=0, PLAY=1, P1_WIN=2, P2_WIN=3 (matches game_state port)
//   PLAYER1/PLAYER2 : encodings used by turn and capture_victim
//   COUNT_W / TIME_W : pawn counter and turn timer widths
package checkers_pkg;

  localparam int unsigned COUNT_W = 4;
  localparam int unsigned TIME_W  = 6;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_P1_WIN = 2'd2,
    ST_P2_WIN = 2'd3
  } game_state_t;

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown.
//   clk, reset_n : clock, synchronous active-low reset (loads TURN_SECONDS)
//   reload       : load TURN_SECONDS (wins over tick)
//   tick         : once-per-second pulse
//   enable       : counting allowed (game in play, not frozen)
//   time_left    : seconds remaining in the current turn
//   expired      : tick arrived while already at 0 (never when TURN_SECONDS is 0)
module turn_timer
  import checkers_pkg::*;
#(
  parameter int unsigned TURN_SECONDS = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reload,
  input  logic              tick,
  input  logic              enable,
  output logic [TIME_W-1:0] time_left,
  output logic              expired
);

  localparam logic [TIME_W-1:0] RELOAD_VAL = TIME_W'(TURN_SECONDS);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      time_left <= RELOAD_VAL;
    end else if (reload) begin
      time_left <= RELOAD_VAL;
    end else if (enable && tick && (time_left != '0)) begin
      time_left <= time_left - TIME_W'(1);
    end
  end

  assign expired = enable && tick && (time_left == '0) && (TURN_SECONDS != 0);

endmodule

// File: rtl/victory_detector.sv
// Checkers game-state tracker driving the victory screen winner flags.
//   clk, reset_n       : clock, synchronous active-low reset
//   new_game           : restart into PLAY with full reload, Player 1 to move
//   capture_valid      : one pawn captured this cycle, owner on capture_victim
//   move_done          : mover finished; toggles turn and reloads the timer
//   sec_tick           : once-per-second pulse for the turn countdown
//   Player_1_v/_2_v    : registered winner flags, held until new_game
//   p1_count/p2_count  : pawns remaining per player
//   turn               : 0 = Player 1 to move, 1 = Player 2
//   time_left          : seconds left in the current turn
//   game_state         : IDLE/PLAY/P1_WIN/P2_WIN
//   illegal_capture    : one-cycle pulse when a capture of the mover's own pawn is rejected
module victory_detector
  import checkers_pkg::*;
#(
  parameter int unsigned PAWNS        = 12,
  parameter int unsigned TURN_SECONDS = 30
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                new_game,
  input  logic                capture_valid,
  input  logic                capture_victim,
  input  logic                move_done,
  input  logic                sec_tick,
  output logic                Player_1_v,
  output logic                Player_2_v,
  output logic [COUNT_W-1:0]  p1_count,
  output logic [COUNT_W-1:0]  p2_count,
  output logic                turn,
  output logic [TIME_W-1:0]   time_left,
  output logic [1:0]          game_state,
  output logic                illegal_capture
);

  localparam logic [COUNT_W-1:0] FULL = COUNT_W'(PAWNS);

  game_state_t        state, state_next;
  logic [COUNT_W-1:0] p1_next, p2_next, victim_count;
  logic               turn_next, illegal_next;
  logic               in_play, legal_cap, win_cap, timeout;
  logic               timer_enable, timer_reload;

  // Decode kept outside the main next-state block so the timer's expired
  // feedback does not form a loop through a single process.
  assign in_play      = (state == ST_PLAY) && !new_game;
  assign legal_cap    = in_play && capture_valid && (capture_victim != turn);
  assign victim_count = (capture_victim == PLAYER2) ? p2_count : p1_count;
  assign win_cap      = legal_cap && (victim_count == COUNT_W'(1));
  // A winning capture freezes the timer even if a tick arrives in the same cycle.
  assign timer_enable = in_play && !win_cap;
  assign timer_reload = new_game || (in_play && !win_cap && !timeout && move_done);

  turn_timer #(
    .TURN_SECONDS (TURN_SECONDS)
  ) u_turn_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .reload    (timer_reload),
    .tick      (sec_tick),
    .enable    (timer_enable),
    .time_left (time_left),
    .expired   (timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      p1_count        <= FULL;
      p2_count        <= FULL;
      turn            <= PLAYER1;
      illegal_capture <= 1'b0;
      Player_1_v      <= 1'b0;
      Player_2_v      <= 1'b0;
    end else begin
      state           <= state_next;
      p1_count        <= p1_next;
      p2_count        <= p2_next;
      turn            <= turn_next;
      illegal_capture <= illegal_next;
      Player_1_v      <= (state_next == ST_P1_WIN);
      Player_2_v      <= (state_next == ST_P2_WIN);
    end
  end

  always_comb begin
    state_next   = state;
    p1_next      = p1_count;
    p2_next      = p2_count;
    turn_next    = turn;
    illegal_next = 1'b0;

    if (new_game) begin
      state_next = ST_PLAY;
      p1_next    = FULL;
      p2_next    = FULL;
      turn_next  = PLAYER1;
    end else if (state == ST_PLAY) begin
      illegal_next = capture_valid && (capture_victim == turn);
      if (win_cap) begin
        if (capture_victim == PLAYER2) begin
          p2_next    = '0;
          state_next = ST_P1_WIN;
        end else begin
          p1_next    = '0;
          state_next = ST_P2_WIN;
        end
      end else if (timeout) begin
        state_next = (turn == PLAYER2) ? ST_P1_WIN : ST_P2_WIN;
      end else begin
        // Capture is judged against the pre-toggle turn, so both apply together.
        if (legal_cap && (victim_count != '0)) begin
          if (capture_victim == PLAYER2) p2_next = p2_count - COUNT_W'(1);
          else                           p1_next = p1_count - COUNT_W'(1);
        end
        if (move_done) turn_next = ~turn;
      end
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_victory_detector.sv
module tb_victory_detector;

  localparam int PAWNS = 12;
  localparam int TSEC  = 3;

  logic       clk = 1'b0;
  logic       reset_n, new_game, capture_valid, capture_victim, move_done, sec_tick;
  logic       Player_1_v, Player_2_v, turn, illegal_capture;
  logic [3:0] p1_count, p2_count;
  logic [5:0] time_left;
  logic [1:0] game_state;

  victory_detector #(
    .PAWNS        (PAWNS),
    .TURN_SECONDS (TSEC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .new_game        (new_game),
    .capture_valid   (capture_valid),
    .capture_victim  (capture_victim),
    .move_done       (move_done),
    .sec_tick        (sec_tick),
    .Player_1_v      (Player_1_v),
    .Player_2_v      (Player_2_v),
    .p1_count        (p1_count),
    .p2_count        (p2_count),
    .turn            (turn),
    .time_left       (time_left),
    .game_state      (game_state),
    .illegal_capture (illegal_capture)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int p1; int p2; int trn; int tl; int ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference game: 0 idle, 1 play, 2 player-1 won, 3 player-2 won.
  int m_st = 0, m_p1 = PAWNS, m_p2 = PAWNS, m_turn = 0, m_tl = TSEC, m_ill = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One edge of the game, applying the rules in their priority order.
  task automatic model_step(input bit rn, ng, cv, vic, md, tk);
    int vcount;
    m_ill = 0;
    if (!rn) begin
      m_st = 0; m_p1 = PAWNS; m_p2 = PAWNS; m_turn = 0; m_tl = TSEC;
    end else if (ng) begin
      m_st = 1; m_p1 = PAWNS; m_p2 = PAWNS; m_turn = 0; m_tl = TSEC;
    end else if (m_st == 1) begin
      if (cv && (vic == m_turn)) m_ill = 1;
      vcount = vic ? m_p2 : m_p1;
      if (cv && vic != m_turn && vcount == 1) begin
        if (vic) begin m_p2 = 0; m_st = 2; end
        else     begin m_p1 = 0; m_st = 3; end
      end else if (tk && m_tl == 0 && TSEC > 0) begin
        m_st = (m_turn == 1) ? 2 : 3;
      end else begin
        if (cv && vic != m_turn && vcount > 0) begin
          if (vic) m_p2 = m_p2 - 1;
          else     m_p1 = m_p1 - 1;
        end
        if (md) begin
          m_turn = 1 - m_turn;
          m_tl   = TSEC;
        end else if (tk && m_tl > 0) begin
          m_tl = m_tl - 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit rn, ng, cv, vic, md, tk);
    exp_t e;
    @(negedge clk);
    reset_n        = rn;
    new_game       = ng;
    capture_valid  = cv;
    capture_victim = vic;
    move_done      = md;
    sec_tick       = tk;
    model_step(rn, ng, cv, vic, md, tk);
    e.st = m_st; e.p1 = m_p1; e.p2 = m_p2; e.trn = m_turn; e.tl = m_tl; e.ill = m_ill;
    sb.push_back(e);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("game_state", int'(game_state), e.st);
        check("p1_count", int'(p1_count), e.p1);
        check("p2_count", int'(p2_count), e.p2);
        check("turn", int'(turn), e.trn);
        check("time_left", int'(time_left), e.tl);
        check("illegal_capture", int'(illegal_capture), e.ill);
        check("Player_1_v", int'(Player_1_v), (e.st == 2) ? 1 : 0);
        check("Player_2_v", int'(Player_2_v), (e.st == 3) ? 1 : 0);
      end
    end
  end

  initial begin
    bit ng;
    reset_n = 1'b0; new_game = 1'b0; capture_valid = 1'b0;
    capture_victim = 1'b0; move_done = 1'b0; sec_tick = 1'b0;

    // Reset, then win Player 1 by taking all of Player 2's pawns.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 1);          // IDLE ignores everything
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < PAWNS; i++) begin
      cyc(1, 0, 1, 1, 0, 0);        // Player 1 captures a Player 2 pawn
      if (i < PAWNS - 1) begin
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
      end
    end
    // Win state ignores captures, ticks and moves.
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, i[0], 1, 1);
    cyc(1, 1, 0, 0, 0, 0);

    // Illegal self capture.
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Player 2 to move times out.
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);

    // Bring Player 1 to one pawn, then a winning capture with move_done and tick.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < PAWNS - 1; i++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0);

    // Reset mid-game with a capture; new_game and capture together.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      if (m_st >= 2 || m_st == 0) ng = ($urandom_range(7) == 0);
      else                        ng = ($urandom_range(199) == 0);
      cyc(($urandom_range(299) != 0), ng,
          ($urandom_range(2) != 0), ($urandom_range(1) == 1),
          ($urandom_range(4) == 0), ($urandom_range(3) == 0));
    end

    cyc(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
